// File: rtl/prefix_adder_word_sequencer.sv
// Multi-cycle wide adder: feeds BITS-wide chunks of WORDS*BITS-bit operands through a Kogge-Stone adder, LSB first.
// Optional subtract mode (sub port) is enabled by defining SEQ_ADDER_SUB_EN.

module kogge_stone_adder #(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            ci,
    output logic [BITS-1:0] s,
    output logic            co
);
    localparam int unsigned LEVELS = (BITS > 1) ? $clog2(BITS) : 0;

    always_comb begin
        logic [BITS-1:0] g, p, gn, pn, c;
        g  = a & b;
        p  = a ^ b;
        gn = g;
        pn = p;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            gn = g;
            pn = p;
            for (int unsigned i = 0; i < BITS; i++) begin
                if (i >= (32'd1 << l)) begin
                    gn[i] = g[i] | (p[i] & g[i - (32'd1 << l)]);
                    pn[i] = p[i] & p[i - (32'd1 << l)];
                end
            end
            g = gn;
            p = pn;
        end
        // g/p now hold group generate/propagate from bit 0 up to each bit
        c[0] = ci;
        for (int unsigned i = 1; i < BITS; i++) begin
            c[i] = g[i-1] | (p[i-1] & ci);
        end
        s  = a ^ b ^ c;
        co = g[BITS-1] | (p[BITS-1] & ci);
    end
endmodule

module prefix_adder_word_sequencer #(
    parameter int unsigned BITS  = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS*WORDS-1:0] a,
    input  logic [BITS*WORDS-1:0] b,
    input  logic                  ci,
`ifdef SEQ_ADDER_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS*WORDS-1:0] s,
    output logic                  co,
    output logic                  busy
);
    localparam int unsigned W     = BITS * WORDS;
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, s_q, s_d;
    logic             carry_q, carry_d, co_q, co_d;
    logic [BITS-1:0]  add_a, add_b, add_s;
    logic             add_co;
    logic             sub_sel;

`ifdef SEQ_ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    kogge_stone_adder #(.BITS(BITS)) u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                add_a = a_q[w*BITS +: BITS];
                add_b = b_q[w*BITS +: BITS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    // subtraction is a + ~b + 1, so the latched ci is replaced by 1
                    b_d     = sub_sel ? ~b : b;
                    carry_d = sub_sel ? 1'b1 : ci;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (idx_q == IDX_W'(w)) begin
                        s_d[w*BITS +: BITS] = add_s;
                    end
                end
                carry_d = add_co;
                if (idx_q == IDX_W'(WORDS - 1)) begin
                    co_d    = add_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign s         = s_q;
    assign co        = co_q;
endmodule

// File: tb/tb_prefix_adder_word_sequencer.sv
// Self-checking bench: table vectors, random ops against an arithmetic model, and multi-cycle corner cases.
// Exercises subtraction only when SEQ_ADDER_SUB_EN is defined.

module tb_prefix_adder_word_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy, ci, co, sub;
    logic [31:0] a, b, s;
    logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1, ci1, co1, sub1;
    logic [7:0]  a1, b1, s1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    prefix_adder_word_sequencer #(.BITS(8), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef SEQ_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .busy      (busy)
    );

    prefix_adder_word_sequencer #(.BITS(8), .WORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .ci        (ci1),
`ifdef SEQ_ADDER_SUB_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .s         (s1),
        .co        (co1),
        .busy      (busy1)
    );

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        vci;
        logic [31:0] exp_s;
        logic        exp_co;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mci, input logic msub);
        if (msub) return {1'b0, ma} + {1'b0, ~mb} + 33'd1;
        return {1'b0, ma} + {1'b0, mb} + {32'd0, mci};
    endfunction

    task automatic start_and_wait(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                                  input logic tsub, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); @(negedge clk); guard++;
        end
        a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); @(negedge clk); lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                          input logic tsub, input logic [31:0] es, input logic eco);
        int lat;
        start_and_wait(ta, tb, tci, tsub, lat);
        chk("latency", lat, 4);
        chk("sum", s, es);
        chk("carry_out", co, eco);
        @(posedge clk); @(negedge clk);
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    task automatic run_op1(input logic [7:0] ta, input logic [7:0] tb, input logic tci);
        int lat = 0;
        logic [8:0] exp;
        exp = {1'b0, ta} + {1'b0, tb} + {8'd0, tci};
        a1 = ta; b1 = tb; ci1 = tci; in_valid1 = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid1 = 1'b0;
        chk("w1_busy", busy1, 1);
        while (!out_valid1 && lat < 20) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        chk("w1_latency", lat, 1);
        chk("w1_sum", s1, exp[7:0]);
        chk("w1_carry_out", co1, exp[8]);
        @(posedge clk); @(negedge clk);
        chk("w1_in_ready", in_ready1, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] ra, rb;
        logic        rci, rsub;
        logic [32:0] m;

        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        vecs[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        vecs[3] = '{32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b1; a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", s, 0);
        chk("rst_co", co, 0);
        chk("rst_busy", busy, 0);
        chk("rst_w1_in_ready", in_ready1, 1);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vci, 1'b0, vecs[i].exp_s, vecs[i].exp_co);

        for (int i = 0; i < 30; i++) begin
            ra = $urandom; rb = $urandom; rci = 1'($urandom_range(0, 1));
`ifdef SEQ_ADDER_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            m = model(ra, rb, rci, rsub);
            run_op(ra, rb, rci, rsub, m[31:0], m[32]);
        end

        // Backpressure: result held while a second request is ignored
        out_ready = 1'b0;
        start_and_wait(32'h12345678, 32'h11111111, 1'b0, 1'b0, lat);
        chk("bp_latency", lat, 4);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k == 2);
            a = 32'h1; b = 32'h1;
            @(posedge clk); @(negedge clk);
            chk("bp_sum_stable", s, 32'h23456789);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        chk("bp_release_busy", busy, 0);

        // Reset while idx==2 discards the operation
        a = 32'hFFFFFFFF; b = 32'h1; ci = 1'b0; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sum", s, 0);
        chk("mid_rst_co", co, 0);
        chk("mid_rst_busy", busy, 0);
        run_op(32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0);

`ifdef SEQ_ADDER_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0);
        run_op(32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1);
        run_op(32'd7, 32'd5, 1'b1, 1'b1, 32'h00000002, 1'b1);
        run_op(32'd9, 32'd9, 1'b0, 1'b0, 32'd18, 1'b0);
`endif

        run_op1(8'h80, 8'h80, 1'b0);
        run_op1(8'hFF, 8'h00, 1'b1);
        run_op1(8'h12, 8'h34, 1'b1);
        for (int i = 0; i < 5; i++)
            run_op1(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/prefix_adder_word_sequencer.md
Name: prefix_adder_word_sequencer

Overview:
- Multi-cycle wide adder built around the existing BITS-wide Kogge-Stone prefix adder, which it instantiates directly.
- Splits WORDS*BITS-bit operands into BITS-wide chunks, LSB chunk first, and feeds one chunk per cycle into the adder.
- Registers each chunk sum, chains the adder's co back into its ci on the next cycle, and presents the full result over a valid/ready handshake.
- Sits directly upstream of the prefix adder: it sequences the adder's inputs and consumes its s/co outputs.

Parameters:
- BITS, 8, chunk width and width of the instantiated prefix adder; legal range 1..128.
- WORDS, 4, number of chunks per operation; legal range >=1. Total width W = BITS*WORDS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept an operation.
- a  input  W  operand A; sampled only on accept.
- b  input  W  operand B; sampled only on accept.
- ci  input  1  carry-in for chunk 0; sampled only on accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- s  output  W  sum, a + b + ci, modulo 2^W.
- co  output  1  carry out of bit W-1.
- busy  output  1  high while in the RUN state.

Behaviour:
- Reset values: in_ready=1, out_valid=0, s=0, co=0, busy=0; state=IDLE, chunk index=0, carry register=0.
- A reset asserted in any state, including mid-RUN, takes effect at the next clock edge. The in-flight operation is discarded and never reported.
- State machine:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, ci into the operand registers, clear idx to 0, and go to RUN.
  - RUN: each cycle the adder receives a_reg[idx*BITS +: BITS], b_reg[idx*BITS +: BITS], and carry_reg as its ci (carry_reg holds the latched ci for idx=0). Write the adder's s into s[idx*BITS +: BITS] and the adder's co into carry_reg, then increment idx. When idx==WORDS-1, also write co from the adder's co and go to DONE.
  - DONE: out_valid=1; s and co are held stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- in_ready is high only in IDLE. An in_valid seen in RUN or DONE is ignored and not queued.
- Latency: the accept edge is cycle 0; out_valid rises exactly WORDS cycles later.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high. A new operation cannot be accepted in the same cycle as the out handshake.
- The idx counter is max(1, $clog2(WORDS)) bits wide and never wraps during an operation. With WORDS=1, RUN lasts exactly one cycle.
- Data path: the adder is purely combinational. Only the operand registers, s, co, carry_reg, idx and the state are sequential.
- s bits of chunks not yet computed keep the previous operation's values until overwritten; the s value is defined only while out_valid=1.
- Driving out_ready while out_valid=0 has no effect.

Optional Feature:
- Macro: SEQ_ADDER_SUB_EN.
- Defined:
  - Adds the port sub (input, 1 bit), sampled on accept.
  - With sub=1: the latched b is inverted and the chunk-0 carry is forced to 1 (the ci input is ignored). The result is s=a-b modulo 2^W; co=1 means no borrow.
  - With sub=0: behaviour is identical to the base block.
- Not defined: the sub port does not exist and the block is add-only.

Test Plan (BITS=8, WORDS=4 unless stated):
- a=0x000000FF, b=0x00000001, ci=0, out_ready=1 -> out_valid 4 cycles after accept; s=0x00000100, co=0.
- a=0xFFFFFFFF, b=0x00000000, ci=1 -> carry ripples through all 4 chunks; s=0x00000000, co=1.
- Backpressure: complete an op with a=0x12345678, b=0x11111111, hold out_ready=0 for 5 cycles and pulse in_valid with a new op -> s=0x23456789 stays stable, in_ready=0, the second op is not accepted; after out_ready=1, in_ready returns 1 one cycle later.
- Reset mid-RUN: assert rst for 1 cycle at idx=2 -> next cycle in_ready=1, out_valid=0, s=0, co=0, busy=0. A following op a=3, b=4 gives s=7.
- SEQ_ADDER_SUB_EN defined: a=5, b=7, sub=1 -> s=0xFFFFFFFE, co=0. Then a=7, b=5, sub=1 -> s=0x00000002, co=1.
- BITS=8, WORDS=1: a=0x80, b=0x80, ci=0 -> out_valid 1 cycle after accept; s=0x00, co=1.
